// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage pipeline: load-use stalls, branch flushes,
// EX operand forwarding, a multi-cycle EX wait FSM with timeout, and saturating event counters.
module pipeline_hazard_ctrl #(
   parameter int CNT_W      = 16,
   parameter int MC_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic [1:0]       ResultSrcE,
   input  logic             PCSrcE,
   input  logic             mc_start,
   input  logic             mc_done,
   input  logic             cnt_clr,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             mc_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam int TMR_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MC_TIMEOUT - 1);

   typedef enum logic {RUN, MC_WAIT} state_t;

   state_t           state, state_nxt;
   logic [TMR_W-1:0] timer, timer_inc;
   logic             lw_stall;
   logic             timeout_set;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rdm,
                                          input logic wem, input logic [4:0] rdw,
                                          input logic wew);
      if (wem && rdm != 5'd0 && rdm == rs)
         return 2'b10;
      else if (wew && rdw != 5'd0 && rdw == rs)
         return 2'b01;
      else
         return 2'b00;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
   assign timer_inc = timer + TMR_W'(1);

   // All hazard outputs are held low while reset is asserted, independent of the clock.
   always_comb begin
      StallF      = 1'b0;
      StallD      = 1'b0;
      StallE      = 1'b0;
      FlushD      = 1'b0;
      FlushE      = 1'b0;
      ForwardAE   = 2'b00;
      ForwardBE   = 2'b00;
      state_nxt   = state;
      timeout_set = 1'b0;
      if (!rst) begin
         ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
         ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
         case (state)
            RUN: begin
               if (PCSrcE) begin
                  FlushD = 1'b1;
                  FlushE = 1'b1;
               end else if (lw_stall) begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  FlushE = 1'b1;
               end
               if (mc_start && !PCSrcE)
                  state_nxt = MC_WAIT;
            end
            MC_WAIT: begin
               StallF = !mc_done;
               StallD = !mc_done;
               StallE = !mc_done;
               if (mc_done) begin
                  state_nxt = RUN;
               end else if (timer_inc == TMR_LAST) begin
                  state_nxt   = RUN;
                  timeout_set = 1'b1;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= RUN;
         timer        <= '0;
         mc_timeout   <= 1'b0;
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         state      <= state_nxt;
         mc_timeout <= timeout_set;
         timer      <= (state == MC_WAIT) ? timer_inc : '0;
         if (cnt_clr) begin
            stall_cycles <= '0;
            flush_events <= '0;
         end else begin
            if (StallF) stall_cycles <= sat_inc(stall_cycles);
            if (FlushE) flush_events <= sat_inc(flush_events);
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a small-counter/short-timeout instance (dut)
// and a default-parameter instance (dut_b) driven from the same inputs.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic       RegWriteM, RegWriteW, PCSrcE, mc_start, mc_done, cnt_clr;
   logic [1:0] ResultSrcE;

   logic       StallF, StallD, StallE, FlushD, FlushE, mc_timeout;
   logic [1:0] ForwardAE, ForwardBE;
   logic [1:0] stall_cycles, flush_events;

   logic        b_StallF, b_StallD, b_StallE, b_FlushD, b_FlushE, b_mc_timeout;
   logic [1:0]  b_ForwardAE, b_ForwardBE;
   logic [15:0] b_stall_cycles, b_flush_events;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.CNT_W(2), .MC_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .mc_start(mc_start), .mc_done(mc_done),
      .cnt_clr(cnt_clr), .StallF(StallF), .StallD(StallD), .StallE(StallE),
      .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .mc_timeout(mc_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   pipeline_hazard_ctrl #(.CNT_W(16), .MC_TIMEOUT(64)) dut_b (
      .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .mc_start(mc_start), .mc_done(mc_done),
      .cnt_clr(cnt_clr), .StallF(b_StallF), .StallD(b_StallD), .StallE(b_StallE),
      .FlushD(b_FlushD), .FlushE(b_FlushE), .ForwardAE(b_ForwardAE), .ForwardBE(b_ForwardBE),
      .mc_timeout(b_mc_timeout), .stall_cycles(b_stall_cycles), .flush_events(b_flush_events)
   );

   typedef struct {
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic       rwm, rww;
      logic [1:0] rsrc;
      logic       pcsrc;
      logic       sf, sd, fd, fe;
      logic [1:0] fa, fb;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00; PCSrcE = 0;
      mc_start = 0; mc_done = 0; cnt_clr = 0;
   endtask

   // Advance to the next falling edge; inputs are changed there and sampled 2ns later.
   task automatic to_negedge();
      @(negedge clk);
   endtask

   task automatic load_use();
      idle();
      RdE = 7; Rs2D = 7; ResultSrcE = 2'b01;
   endtask

   task automatic clear_counters();
      to_negedge(); idle(); cnt_clr = 1;
      to_negedge(); idle();
   endtask

   initial begin
      //             rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rsrc pc  sf sd fd fe fa fb
      vecs[0]  = '{0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0};
      vecs[1]  = '{0, 0, 5, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[2]  = '{0, 0, 0, 5, 0, 3, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[3]  = '{0, 0, 5, 5, 0, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
      vecs[4]  = '{0, 0, 9, 9, 0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 2};
      vecs[5]  = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0};
      vecs[6]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0};
      vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
      vecs[8]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0};
      vecs[10] = '{0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
      vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};

      // Reset state, with inputs that would otherwise flush and forward
      idle();
      rst = 1;
      PCSrcE = 1; RdM = 5; RegWriteM = 1; Rs1E = 5;
      #2;
      check("rst_flushd", FlushD, 0);
      check("rst_flushe", FlushE, 0);
      check("rst_fwda", ForwardAE, 0);
      check("rst_stall_cycles", stall_cycles, 0);
      check("rst_flush_events", flush_events, 0);
      check("rst_mc_timeout", mc_timeout, 0);
      to_negedge(); idle(); rst = 0;

      // Combinational vectors in RUN
      for (int i = 0; i < 12; i++) begin
         to_negedge();
         idle();
         Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
         RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
         RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
         ResultSrcE = vecs[i].rsrc; PCSrcE = vecs[i].pcsrc;
         #2;
         check($sformatf("vec%0d_stallf", i), StallF, vecs[i].sf);
         check($sformatf("vec%0d_stalld", i), StallD, vecs[i].sd);
         check($sformatf("vec%0d_stalle", i), StallE, 0);
         check($sformatf("vec%0d_flushd", i), FlushD, vecs[i].fd);
         check($sformatf("vec%0d_flushe", i), FlushE, vecs[i].fe);
         check($sformatf("vec%0d_fwda", i), ForwardAE, vecs[i].fa);
         check($sformatf("vec%0d_fwdb", i), ForwardBE, vecs[i].fb);
      end

      // Load-use: one stall cycle counted
      clear_counters();
      #2 check("clr_stall_cycles", stall_cycles, 0);
      to_negedge(); load_use();
      #2 check("lu_stall_cycles_before", stall_cycles, 0);
      to_negedge(); idle();
      #2;
      check("lu_stall_cycles_after", stall_cycles, 1);
      check("lu_flush_events_after", flush_events, 1);
      check("lu_stallf_released", StallF, 0);

      // Branch with mc_start: flush counted, op squashed
      to_negedge(); idle(); PCSrcE = 1; mc_start = 1;
      #2 check("br_stallf", StallF, 0);
      to_negedge(); idle();
      #2;
      check("br_flush_events", b_flush_events, 2);
      check("br_squash_stalle", StallE, 0);
      check("br_squash_b_stalle", b_StallE, 0);

      // mc_done in RUN is ignored
      to_negedge(); load_use(); mc_done = 1;
      #2 check("run_done_ignored", b_StallF, 1);

      // Multi-cycle op completing after 3 stall cycles (default instance)
      to_negedge(); idle(); mc_start = 1;
      #2 check("mc_start_cycle_stalle", b_StallE, 0);
      for (int c = 1; c <= 3; c++) begin
         to_negedge(); idle();
         #2;
         check($sformatf("mc_wait%0d_stallf", c), b_StallF, 1);
         check($sformatf("mc_wait%0d_stalle", c), b_StallE, 1);
         check($sformatf("mc_wait%0d_flushe", c), b_FlushE, 0);
      end
      to_negedge(); idle(); mc_done = 1;
      #2;
      check("mc_done_stallf", b_StallF, 0);
      check("mc_done_stalle", b_StallE, 0);
      to_negedge(); idle(); PCSrcE = 1;
      #2 check("mc_back_run_flushd", b_FlushD, 1);

      // Timeout on the MC_TIMEOUT=4 instance
      to_negedge(); idle(); mc_start = 1;
      for (int c = 1; c <= 3; c++) begin
         to_negedge(); idle();
         #2;
         check($sformatf("to_wait%0d_stallf", c), StallF, 1);
         check($sformatf("to_wait%0d_timeout", c), mc_timeout, 0);
      end
      to_negedge(); idle();
      #2;
      check("to_pulse", mc_timeout, 1);
      check("to_stallf_released", StallF, 0);
      to_negedge(); idle();
      #2 check("to_pulse_end", mc_timeout, 0);

      // Saturation with CNT_W=2, then clear
      clear_counters();
      for (int c = 0; c < 5; c++) begin
         to_negedge(); load_use();
      end
      to_negedge(); idle();
      #2 check("sat_stall_cycles", stall_cycles, 3);
      to_negedge(); idle(); cnt_clr = 1;
      #2 check("sat_hold_before_clr", stall_cycles, 3);
      to_negedge(); idle();
      #2 check("sat_cleared", stall_cycles, 0);

      // mc_start during MC_WAIT is ignored; async reset mid-MC_WAIT
      to_negedge(); idle(); mc_start = 1;
      #2 check("wait_start_ignored_b", b_StallE, 1);
      to_negedge(); idle();
      #2 check("rstwait_stalle_before", StallE, 1);
      rst = 1;
      #1;
      check("rstwait_stallf", StallF, 0);
      check("rstwait_stalle", StallE, 0);
      check("rstwait_b_stalle", b_StallE, 0);
      to_negedge(); rst = 0;
      #2 check("rstwait_run", StallE, 0);
      for (int c = 0; c < 4; c++) begin
         to_negedge();
         #2 check($sformatf("rstwait_no_timeout%0d", c), mc_timeout, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
